set_way_enable: RTL and testbench

- Parametrised, registered successor to the single-level block-enable decoder.
- Maps a set index plus a way choice to a flat one-hot enable over all NUM_SETS×WAYS cache blocks.
- Keeps true-LRU age state per set, so the fill victim is chosen inside the block.
- Sits between the cache controller (lookup result, fill request) and the data/tag arrays (per-block write/read enable).

---
 rtl/cache_pkg.sv | 25 ++
 rtl/set_way_enable_if.sv | 34 +++
 rtl/lru_age_update.sv | 41 ++++
 rtl/set_way_enable.sv | 85 ++++++++
 tb/tb_set_way_enable.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and constants for the set/way enable block.
// Holds the default geometry, the way-width helper, the age type and the request kinds.
package cache_pkg;

  localparam int SET_BITS_DEF = 6;
  localparam int WAYS_DEF     = 2;
  localparam int MAX_WAY_BITS = 3;

  function automatic int way_bits(input int n);
    int b;
    b = 0;
    for (int i = 0; i < 8; i++)
      if ((1 << i) < n) b = i + 1;
    return b;
  endfunction

  typedef logic [MAX_WAY_BITS-1:0] age_t;

  typedef enum logic [1:0] {
    HIT,
    FILL,
    PROBE
  } req_kind_e;

endpackage

// File: rtl/set_way_enable_if.sv
// Request/enable bundle between the cache controller and the enable block.
// master: controller drives req_*; slave: the block drives en_valid, blk_en, sel_way.
interface set_way_enable_if
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int WAYS     = WAYS_DEF
) ();

  localparam int WB = way_bits(WAYS);
  localparam int NB = (2 ** SET_BITS) * WAYS;

  logic                req_valid;
  logic [SET_BITS-1:0] req_set;
  logic                req_hit;
  logic [WB-1:0]       req_hit_way;
  logic                req_fill;
  logic                en_valid;
  logic [NB-1:0]       blk_en;
  logic [WB-1:0]       sel_way;

  modport master (
    output req_valid, req_set, req_hit,
    output req_hit_way, req_fill,
    input  en_valid, blk_en, sel_way
  );

  modport slave (
    input  req_valid, req_set, req_hit,
    input  req_hit_way, req_fill,
    output en_valid, blk_en, sel_way
  );

endinterface

// File: rtl/lru_age_update.sv
// True-LRU age update for one set: returns the touched age row and the victim.
// Ports: ages_in/ages_out (WAYS x WB packed row), touch_way in, victim out.
module lru_age_update
  import cache_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  parameter int WB   = way_bits(WAYS)
) (
  input  logic [WAYS*WB-1:0] ages_in,
  input  logic [WB-1:0]      touch_way,
  output logic [WAYS*WB-1:0] ages_out,
  output logic [WB-1:0]      victim
);

  age_t old_age;
  age_t cur;
  age_t inc;

  always_comb begin
    victim  = '0;
    old_age = '0;
    cur     = '0;
    inc     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_in[w*WB +: WB] == WB'(WAYS - 1))
        victim = WB'(w);
      if (WB'(w) == touch_way)
        old_age = age_t'(ages_in[w*WB +: WB]);
    end
    ages_out = ages_in;
    for (int w = 0; w < WAYS; w++) begin
      cur = age_t'(ages_in[w*WB +: WB]);
      inc = cur + age_t'(1);
      if (WB'(w) == touch_way)
        ages_out[w*WB +: WB] = '0;
      else if (cur < old_age)
        ages_out[w*WB +: WB] = inc[WB-1:0];
    end
  end

endmodule

// File: rtl/set_way_enable.sv
// Registered set/way to one-hot block enable decoder with per-set true-LRU.
// Ports: clk, rst_n (async low), bus (slave modport of set_way_enable_if).
module set_way_enable
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int WAYS     = WAYS_DEF
) (
  input logic             clk,
  input logic             rst_n,
  set_way_enable_if.slave bus
);

  localparam int WB = way_bits(WAYS);
  localparam int NS = 2 ** SET_BITS;
  localparam int NB = NS * WAYS;

  logic [WAYS*WB-1:0] age_q [NS];
  logic [WAYS*WB-1:0] row;
  logic [WAYS*WB-1:0] row_nx;
  logic [WB-1:0]      victim;
  logic [WB-1:0]      way;
  logic               touch;
  req_kind_e          kind;

  logic               en_valid_q;
  logic [NB-1:0]      blk_en_q;
  logic [WB-1:0]      sel_way_q;

  assign row = age_q[bus.req_set];

  // A hit wins over a fill when both are raised.
  always_comb begin
    kind = PROBE;
    if (bus.req_hit)
      kind = HIT;
    else if (bus.req_fill)
      kind = FILL;
  end

  assign way   = (kind == HIT) ? bus.req_hit_way : victim;
  assign touch = bus.req_valid && (kind != PROBE);

  lru_age_update #(
    .WAYS (WAYS),
    .WB   (WB)
  ) u_lru (
    .ages_in   (row),
    .touch_way (way),
    .ages_out  (row_nx),
    .victim    (victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w*WB +: WB] <= WB'(WAYS - 1 - w);
    end else if (touch) begin
      age_q[bus.req_set] <= row_nx;
    end
  end

  // {set, way} equals set*WAYS + way since WAYS is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_valid_q <= 1'b0;
      blk_en_q   <= '0;
      sel_way_q  <= '0;
    end else begin
      en_valid_q <= bus.req_valid;
      blk_en_q   <= '0;
      if (bus.req_valid) begin
        sel_way_q <= way;
        if (touch)
          blk_en_q <= NB'(1) << {bus.req_set, way};
      end
    end
  end

  assign bus.en_valid = en_valid_q;
  assign bus.blk_en   = blk_en_q;
  assign bus.sel_way  = sel_way_q;

endmodule

// File: tb/tb_set_way_enable.sv
// Self-checking bench: 2-way and 4-way instances against a timestamp LRU model.
// Directed scenarios first, then randomized request streams.
module tb_set_way_enable;

  logic clk;
  logic rst_n;

  set_way_enable_if #(.SET_BITS(6), .WAYS(2)) b2 ();
  set_way_enable_if #(.SET_BITS(6), .WAYS(4)) b4 ();

  set_way_enable #(.SET_BITS(6), .WAYS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  set_way_enable #(.SET_BITS(6), .WAYS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: last-use timestamp per (cfg, set, way); oldest is the victim.
  int ts [2][64][8];
  int tick;
  int exp_sel [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < 8; w++)
          ts[c][s][w] = w;
      exp_sel[c] = 0;
    end
    tick = 16;
  endtask

  task automatic drive(input int c, input bit v, input int s,
                       input bit h, input int hw, input bit f);
    if (c == 0) begin
      b2.req_valid   = v;
      b2.req_set     = 6'(s);
      b2.req_hit     = h;
      b2.req_hit_way = 1'(hw);
      b2.req_fill    = f;
    end else begin
      b4.req_valid   = v;
      b4.req_set     = 6'(s);
      b4.req_hit     = h;
      b4.req_hit_way = 2'(hw);
      b4.req_fill    = f;
    end
  endtask

  task automatic sample(input int c, output bit ev,
                        output logic [255:0] be, output int sw);
    if (c == 0) begin
      ev = b2.en_valid;
      be = 256'(b2.blk_en);
      sw = int'(b2.sel_way);
    end else begin
      ev = b4.en_valid;
      be = 256'(b4.blk_en);
      sw = int'(b4.sel_way);
    end
  endtask

  // One cycle: drive, clock, check the registered result of this request.
  task automatic step(input int c, input bit v, input int s,
                      input bit h, input int hw, input bit f,
                      input string nm);
    int nw;
    int way;
    bit ee;
    logic [255:0] eb;
    bit ev;
    logic [255:0] be;
    int sw;
    nw  = (c != 0) ? 4 : 2;
    way = 0;
    for (int w = 1; w < nw; w++)
      if (ts[c][s][w] < ts[c][s][way]) way = w;
    if (h) way = hw;
    drive(c, v, s, h, hw, f);
    drive(1 - c, 1'b0, 0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    ee = v;
    eb = '0;
    if (v) begin
      exp_sel[c] = way;
      if (h || f) begin
        eb = 256'd1 << (s * nw + way);
        tick++;
        ts[c][s][way] = tick;
      end
    end
    sample(c, ev, be, sw);
    checks++;
    if (ev !== ee) begin
      failures++;
      $display("FAIL %s en_valid got=%0b exp=%0b", nm, ev, ee);
    end
    checks++;
    if (be !== eb) begin
      failures++;
      $display("FAIL %s blk_en got=%h exp=%h", nm, be, eb);
    end
    checks++;
    if (sw !== exp_sel[c]) begin
      failures++;
      $display("FAIL %s sel_way got=%0d exp=%0d", nm, sw, exp_sel[c]);
    end
  endtask

  task automatic check_zero(input string nm);
    bit ev;
    logic [255:0] be;
    int sw;
    for (int c = 0; c < 2; c++) begin
      sample(c, ev, be, sw);
      checks++;
      if (ev !== 1'b0 || be !== '0 || sw !== 0) begin
        failures++;
        $display("FAIL %s cfg%0d got ev=%0b blk=%h sel=%0d exp all zero",
                 nm, c, ev, be, sw);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 5, 0, 0, 0, "probe5");
    step(0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_fill_rotation();
    step(0, 1, 5, 0, 0, 1, "fill_a");
    step(0, 1, 5, 0, 0, 1, "fill_b");
    step(0, 1, 5, 0, 0, 1, "fill_c");
    step(0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_hit_lru();
    step(0, 1, 7, 0, 0, 1, "hl_fill");
    step(0, 1, 7, 1, 0, 0, "hl_hit");
    step(0, 1, 7, 0, 0, 1, "hl_fill2");
    step(0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_ways4();
    for (int i = 0; i < 4; i++)
      step(1, 1, 63, 0, 0, 1, "w4_fill");
    step(1, 1, 63, 1, 1, 0, "w4_hit1");
    step(1, 1, 63, 0, 0, 1, "w4_fillv0");
    step(1, 1, 63, 0, 0, 1, "w4_fillv2");
    step(1, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_isolation();
    step(0, 1, 3, 1, 1, 1, "hit_and_fill");
    step(0, 1, 0, 0, 0, 1, "fill_s0");
    step(0, 1, 1, 0, 0, 1, "fill_s1");
    step(0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic test_mid_reset();
    step(0, 1, 5, 0, 0, 1, "mr_fill_a");
    step(0, 1, 5, 0, 0, 1, "mr_fill_b");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 5, 0, 0, 0, "post_reset_probe");
    step(1, 1, 5, 0, 0, 1, "post_reset_fill4");
  endtask

  task automatic test_random(input int c, input int n);
    int nw;
    int s;
    int k;
    nw = (c != 0) ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 9));
      step(c, k != 0, s, k >= 5, int'($urandom_range(0, nw - 1)),
           (k >= 2 && k <= 4) || (k >= 7), "rand");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    model_reset();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    test_reset();
    test_fill_rotation();
    test_hit_lru();
    test_ways4();
    test_isolation();
    test_mid_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
